// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the boot-time BRAM loader.
// State encodings, byte/word geometry and the default ACK byte.
package bram_loader_pkg;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int         BYTE_W       = 8;
  localparam int         WORD_BYTES   = 4;
  localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;

  // Number of whole words addressable by an addrw-bit byte address.
  function automatic logic [31:0] word_capacity(input int addrw, input int word_len);
    return 32'(1) << (addrw - word_len);
  endfunction

endpackage

// File: rtl/bram_loader_if.sv
// UART byte stream, ACK handshake and RAM write port seen by the loader.
// master = loader side, slave = UART/RAM environment side.
interface bram_loader_if #(
  parameter int ADDRW = 15,
  parameter int DATAW = 32
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             tx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_din;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, mem_we, mem_addr, mem_din
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/bram_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word.
// word/word_vld are valid combinationally in the cycle the 4th byte arrives.
module bram_loader_byte_packer
  import bram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [31:0]       word,
  output logic              word_vld
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= 2'd0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Lanes 0..2 are stored; lane 3 bypasses straight into the output word.
  always_ff @(posedge clk) begin
    if (byte_vld) begin
      case (byte_cnt)
        2'd0:    shift_reg[7:0]   <= byte_in;
        2'd1:    shift_reg[15:8]  <= byte_in;
        2'd2:    shift_reg[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word     = {byte_in, shift_reg};
  assign word_vld = byte_vld && (byte_cnt == LAST_LANE);

endmodule

// File: rtl/bram_loader.sv
// Boot loader: parses a length-prefixed LE word stream from the UART,
// writes the words to BRAM port A, then returns an ACK byte.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int         DATAW    = 32,
  parameter int         ADDRW    = 15,
  parameter int         WORD_LEN = 2,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  bram_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int          IDX_W    = ADDRW - WORD_LEN;
  localparam logic [31:0] CAPACITY = word_capacity(ADDRW, WORD_LEN);

  state_t      state, state_nxt;
  logic [31:0] len;
  logic [31:0] word_cnt;
  logic [31:0] word;
  logic        word_vld;
  logic        byte_vld;
  logic        rearm;
  logic        last_word;
  logic        tx_valid;

  assign byte_vld  = bus.rx_valid && (state == S_LEN || state == S_DATA);
  assign rearm     = start && (state == S_DONE);
  assign last_word = ((word_cnt + 32'd1) == len);

  bram_loader_byte_packer u_packer (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (rearm),
    .byte_vld (byte_vld),
    .byte_in  (bus.rx_data),
    .word     (word),
    .word_vld (word_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_LEN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:   if (word_vld) state_nxt = (word == 32'd0) ? S_ACK : S_DATA;
      S_DATA:  if (word_vld && last_word) state_nxt = S_ACK;
      S_ACK:   if (bus.tx_ready) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_LEN;
      default: state_nxt = S_LEN;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    tx_valid = 1'b0;
    case (state)
      S_LEN, S_DATA: busy = 1'b1;
      S_ACK: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_valid ? ACK_BYTE : 8'h00;

  // Word commit: the write lands one cycle after the 4th byte; words past
  // the end of the RAM are counted but never written (no wrap-around).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len          <= 32'd0;
      word_cnt     <= 32'd0;
      overflow     <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (rearm) begin
        word_cnt <= 32'd0;
        overflow <= 1'b0;
      end
      if (state == S_LEN && word_vld) begin
        len <= word;
      end
      if (state == S_DATA && word_vld) begin
        word_cnt <= word_cnt + 32'd1;
        if (word_cnt < CAPACITY) begin
          bus.mem_we   <= 1'b1;
          bus.mem_addr <= {word_cnt[IDX_W-1:0], {WORD_LEN{1'b0}}};
          bus.mem_din  <= DATAW'(word);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: two instances (full-size RAM and a 4-word
// RAM) receive identical stimulus; write ports are logged on the falling edge.
module tb_bram_loader;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;

  always #5 clk = ~clk;

  bram_loader_if #(.ADDRW(15), .DATAW(32)) bus1 ();
  bram_loader_if #(.ADDRW(4),  .DATAW(32)) bus2 ();

  assign bus1.rx_valid = rx_valid;
  assign bus1.rx_data  = rx_data;
  assign bus1.tx_ready = tx_ready;
  assign bus2.rx_valid = rx_valid;
  assign bus2.rx_data  = rx_data;
  assign bus2.tx_ready = tx_ready;

  logic busy1, done1, ovf1, busy2, done2, ovf2;

  bram_loader #(.DATAW(32), .ADDRW(15), .WORD_LEN(2), .ACK_BYTE(8'hAA)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .bus(bus1.master),
    .busy(busy1), .done(done1), .overflow(ovf1)
  );

  bram_loader #(.DATAW(32), .ADDRW(4), .WORD_LEN(2), .ACK_BYTE(8'hAA)) dut2 (
    .clk(clk), .rstn(rstn), .start(start), .bus(bus2.master),
    .busy(busy2), .done(done2), .overflow(ovf2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] wa1[$], wd1[$], wa2[$], wd2[$];
  int          wc1[$];
  int          b4_cyc[$];
  logic [31:0] fw[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus1.mem_we) begin
      wa1.push_back(32'(bus1.mem_addr));
      wd1.push_back(bus1.mem_din);
      wc1.push_back(cyc);
    end
    if (bus2.mem_we) begin
      wa2.push_back(32'(bus2.mem_addr));
      wd2.push_back(bus2.mem_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit is_data);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (k == 3 && is_data) b4_cyc.push_back(cyc);
      if (gaps) idle();
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    send_word(32'(n), gaps, 1'b0);
    for (int i = 0; i < n; i++) send_word(fw[i], gaps, 1'b1);
    if (!gaps) idle();
  endtask

  task automatic clear_log();
    wa1.delete(); wd1.delete(); wc1.delete();
    wa2.delete(); wd2.delete(); b4_cyc.delete();
  endtask

  task automatic do_ack(input int hold, input string tag);
    int t = 0;
    while (!bus1.tx_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_tx_valid_up"}, 32'(bus1.tx_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_tx_valid_hold"}, 32'(bus1.tx_valid), 32'd1);
      check({tag, "_tx_data"}, 32'(bus1.tx_data), 32'h0000_00AA);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    check({tag, "_tx_data_acc"}, 32'(bus1.tx_data), 32'h0000_00AA);
    @(negedge clk);
    tx_ready = 1'b0;
    check({tag, "_tx_valid_drop"}, 32'(bus1.tx_valid), 32'd0);
    check({tag, "_tx_data_idle"}, 32'(bus1.tx_data), 32'd0);
    check({tag, "_done"}, 32'(done1), 32'd1);
    check({tag, "_busy_done"}, 32'(busy1), 32'd0);
  endtask

  task automatic verify_writes1(input string tag, input int n);
    check({tag, "_wr_count"}, 32'(wa1.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wa1.size()) begin
        check({tag, "_wr_addr"}, wa1[i], 32'(i * 4));
        check({tag, "_wr_data"}, wd1[i], fw[i]);
        check({tag, "_wr_latency"}, 32'(wc1[i]), 32'(b4_cyc[i] + 1));
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mem_we",   32'(bus1.mem_we),   32'd0);
    check("rst_mem_addr", 32'(bus1.mem_addr), 32'd0);
    check("rst_mem_din",  bus1.mem_din,       32'd0);
    check("rst_tx_valid", 32'(bus1.tx_valid), 32'd0);
    check("rst_tx_data",  32'(bus1.tx_data),  32'd0);
    check("rst_done",     32'(done1),         32'd0);
    check("rst_overflow", 32'(ovf1),          32'd0);
    rstn = 1'b1;

    // Two words with gaps between bytes.
    clear_log();
    fw[0] = 32'h1234_5678;
    fw[1] = 32'hDEAD_BEEF;
    send_frame(2, 1'b1);
    check("t1_busy_ack", 32'(busy1), 32'd1);
    check("t1_not_done", 32'(done1), 32'd0);
    do_ack(0, "t1");
    verify_writes1("t1", 2);

    // Zero-length frame, ACK stalled for five cycles.
    pulse_start();
    check("t2_rearm_done", 32'(done1), 32'd0);
    clear_log();
    send_frame(0, 1'b1);
    do_ack(5, "t2");
    check("t2_no_write", 32'(wa1.size()), 32'd0);

    // Back-to-back bytes, three words.
    pulse_start();
    clear_log();
    fw[0] = 32'h0302_0100;
    fw[1] = 32'hA5A5_5A5A;
    fw[2] = 32'hFFFF_FFFF;
    send_frame(3, 1'b0);
    do_ack(0, "t3");
    verify_writes1("t3", 3);

    // Five words: the 4-word RAM instance drops the last one.
    pulse_start();
    clear_log();
    fw[0] = 32'h1111_0000;
    fw[1] = 32'h2222_0001;
    fw[2] = 32'h3333_0002;
    fw[3] = 32'h4444_0003;
    fw[4] = 32'h5555_0004;
    send_frame(5, 1'b1);
    do_ack(0, "t4");
    verify_writes1("t4", 5);
    check("t4_small_done",     32'(done2),       32'd1);
    check("t4_small_overflow", 32'(ovf2),        32'd1);
    check("t4_big_overflow",   32'(ovf1),        32'd0);
    check("t4_small_count",    32'(wa2.size()),  32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa2.size()) begin
        check("t4_small_addr", wa2[i], 32'(i * 4));
        check("t4_small_data", wd2[i], fw[i]);
      end
    end

    // Bytes arriving in S_DONE are ignored; start re-arms and clears overflow.
    clear_log();
    fw[0] = 32'h0BAD_F00D;
    send_frame(1, 1'b1);
    check("t6_ignored_wr",  32'(wa1.size() + wa2.size()), 32'd0);
    check("t6_still_done",  32'(done1),        32'd1);
    check("t6_no_ack",      32'(bus1.tx_valid), 32'd0);
    check("t6_ovf_sticky",  32'(ovf2),         32'd1);
    pulse_start();
    check("t6_ovf_cleared", 32'(ovf2),  32'd0);
    check("t6_busy",        32'(busy1), 32'd1);
    clear_log();
    fw[0] = 32'hCAFE_F00D;
    send_frame(1, 1'b1);
    do_ack(0, "t6");
    verify_writes1("t6", 1);
    check("t6_small_count", 32'(wa2.size()), 32'd1);
    if (wa2.size() > 0) check("t6_small_addr", wa2[0], 32'd0);
    check("t6_small_ovf", 32'(ovf2), 32'd0);

    // Reset mid-frame after length plus two data bytes.
    pulse_start();
    clear_log();
    send_word(32'd2, 1'b1, 1'b0);
    send_byte(8'h11);
    idle();
    send_byte(8'h22);
    idle();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t5_rst_we",   32'(bus1.mem_we), 32'd0);
    check("t5_rst_done", 32'(done1),       32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("t5_no_partial", 32'(wa1.size()), 32'd0);
    clear_log();
    fw[0] = 32'h0BAD_C0DE;
    send_frame(1, 1'b1);
    do_ack(0, "t5");
    verify_writes1("t5", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
